dht11_reader: RTL

Sequential controller for the DHT11 single-wire humidity/temperature sensor. It issues the host start pulse, checks the sensor response, times 40 data bits and verifies the checksum. On success it presents humidity and temperature bytes. It sits between the board-level open-drain pad (tristate handled in top) and user logic.

---
 rtl/dht11_pkg.sv | 25 ++
 rtl/dht11_sync.sv | 33 +++
 rtl/dht11_reader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor reader.
package dht11_pkg;

  // Controller states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  localparam int FRAME_BITS = 40;  // 4 data bytes + 1 checksum byte
  localparam int US_W       = 15;  // microsecond counter width (saturating)
  localparam int IDX_W      = 6;   // enough to count FRAME_BITS

  // Sum of the four data bytes modulo 256; the sensor's checksum byte must match it.
  function automatic logic [7:0] frame_sum(input logic [FRAME_BITS-1:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the raw pad level, with single-cycle rise/fall pulses.
// Everything resets to 1 because the idle bus is pulled high.
module dht11_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resample the asynchronous pad and keep one extra stage for edge detection.
  // NOTE: non-blocking assignments make the three stages shift together, one per clock;
  // blocking ones would collapse them into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/dht11_reader.sv
// DHT11 read controller: drives the host start pulse, follows the sensor's
// response, times 40 data bits by the width of their high phase and checks
// the checksum before publishing humidity/temperature bytes.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       chk_err,
  output logic       timeout_err
);

  localparam int DIV   = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [US_W-1:0]  START_LAST = US_W'(START_LOW_US - 1);
  localparam logic [US_W-1:0]  TMO_LAST   = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0]  BIT_THR    = US_W'(BIT_THRESH_US);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(FRAME_BITS - 1);

  state_t                  state;
  state_t                  state_next;
  logic [PRE_W-1:0]        pre_cnt;
  logic                    tick;
  logic [US_W-1:0]         us_cnt;
  logic [IDX_W-1:0]        bit_idx;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    rise;
  logic                    fall;
  logic                    state_change;
  logic                    start_done;
  logic                    tmo_hit;
  logic                    bit_val;
  logic                    sum_ok;
  logic                    accept;
  logic                    tmo_set;
  logic                    shift_en;
  logic                    clr_idx;

  dht11_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (dht_in),
    .rise (rise),
    .fall (fall)
  );

  assign tick         = (pre_cnt == PRE_LAST);
  assign state_change = (state_next != state);
  // us_cnt does not yet include the microsecond in progress, so "elapsed reaches N"
  // is seen as us_cnt == N-1 on a tick, and "high longer than threshold" as us_cnt >= threshold.
  assign start_done   = tick && (us_cnt >= START_LAST);
  assign tmo_hit      = tick && (us_cnt >= TMO_LAST);
  assign bit_val      = (us_cnt >= BIT_THR);
  assign sum_ok       = (frame_sum(shreg) == shreg[7:0]);

  assign dht_oe = (state == S_START_LOW);
  assign busy   = (state != S_IDLE);

  // State register; reset drops to IDLE at once, which also releases the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode; in every waiting state an edge takes priority over the timeout.
  // NOTE: every output of this block gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    tmo_set    = 1'b0;
    shift_en   = 1'b0;
    clr_idx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_START_LOW;
          accept     = 1'b1;
        end
      end
      S_START_LOW: begin
        if (start_done) state_next = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (fall) state_next = S_RESP_LOW;
        else if (tmo_hit) begin
          state_next = S_IDLE;
          tmo_set    = 1'b1;
        end
      end
      S_RESP_LOW: begin
        if (rise) state_next = S_RESP_HIGH;
        else if (tmo_hit) begin
          state_next = S_IDLE;
          tmo_set    = 1'b1;
        end
      end
      S_RESP_HIGH: begin
        if (fall) begin
          state_next = S_BIT_LOW;
          clr_idx    = 1'b1;
        end else if (tmo_hit) begin
          state_next = S_IDLE;
          tmo_set    = 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (rise) state_next = S_BIT_HIGH;
        else if (tmo_hit) begin
          state_next = S_IDLE;
          tmo_set    = 1'b1;
        end
      end
      S_BIT_HIGH: begin
        if (fall) begin
          shift_en   = 1'b1;
          state_next = (bit_idx == LAST_BIT) ? S_CHECK : S_BIT_LOW;
        end else if (tmo_hit) begin
          state_next = S_IDLE;
          tmo_set    = 1'b1;
        end
      end
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Microsecond timebase: prescaler and saturating us counter, both restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else if (state_change) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick && (us_cnt != '1)) us_cnt <= us_cnt + US_W'(1);
    end
  end

  // Bit capture: MSB-first shift register and count of bits taken.
  // NOTE: the shift register is reset even though every frame overwrites it, so the
  // checksum logic never sees X after power-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      if (clr_idx) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {shreg[FRAME_BITS-2:0], bit_val};
        bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

  // User-facing results: data and valid update only on a good checksum; errors are sticky until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= 1'b0;
      hum_int     <= '0;
      hum_dec     <= '0;
      temp_int    <= '0;
      temp_dec    <= '0;
      chk_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        chk_err     <= 1'b0;
        timeout_err <= 1'b0;
      end
      if (tmo_set) timeout_err <= 1'b1;
      if (state == S_CHECK) begin
        if (sum_ok) begin
          hum_int  <= shreg[39:32];
          hum_dec  <= shreg[31:24];
          temp_int <= shreg[23:16];
          temp_dec <= shreg[15:8];
          valid    <= 1'b1;
        end else begin
          chk_err <= 1'b1;
        end
      end
    end
  end

endmodule
